// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and state encoding for the fetch sequencer.
// HALT is present only in builds with FETCH_MISALIGN_CHK_EN defined.
`ifndef XLEN
`define XLEN 64
`endif

package fetch_ctrl_pkg;

    localparam int          INST_W       = 32;
    localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DROP = 3'd3,
        HOLD = 3'd4
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        HALT = 3'd5
`endif
    } state_t;

endpackage

// File: rtl/REG_RST.sv
// Register with load enable and asynchronous active-high reset to RSTVAL.
// Latency: 1 cycle from d to q when en is high.
// Backpressure: none; q holds its value whenever en is low.
module REG_RST #(
    parameter int           W      = 1,
    parameter logic [W-1:0] RSTVAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RSTVAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one imem request at a time, drops stale responses.
// Latency: first request 1 cycle after reset; response to inst_valid 1 cycle; 3 cycles/instr at best.
// Backpressure: holds the instruction until inst_ready; FETCH_MISALIGN_CHK_EN adds the misaligned-target HALT.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int              XLEN     = `XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trap_valid,
    input  logic [XLEN-1:0]   trap_pc,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   inst_pc
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic              fetch_misalign,
    output logic [XLEN-1:0]   fetch_misalign_pc
`endif
);

    state_t            state_q;
    state_t            state_d;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   pc_d;
    logic              pc_ld;
    logic              cap;
    logic              redir;
    logic [XLEN-1:0]   tgt;
    logic [INST_W-1:0] inst_q;
    logic [XLEN-1:0]   inst_pc_q;

    // Trap always wins over a branch redirect.
    assign redir = trap_valid | redirect_valid;

`ifdef FETCH_MISALIGN_CHK_EN
    logic tgt_bad;
    assign tgt     = trap_valid ? trap_pc : redirect_pc;
    assign tgt_bad = (tgt[1:0] != 2'b00);
`else
    assign tgt     = (trap_valid ? trap_pc : redirect_pc) & ~XLEN'(3);
`endif

    always_comb begin
        state_d = state_q;
        pc_ld   = 1'b0;
        pc_d    = tgt;
        cap     = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (redir) begin
                    pc_ld   = 1'b1;
                    state_d = imem_req_ready ? DROP : REQ;
                end else if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redir) begin
                    pc_ld   = 1'b1;
                    state_d = imem_rsp_valid ? REQ : DROP;
                end else if (imem_rsp_valid) begin
                    cap     = 1'b1;
                    state_d = HOLD;
                end
            end
            DROP: begin
                // A late redirect only retargets; the stale response still has to drain.
                pc_ld = redir;
                if (imem_rsp_valid) begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (redir) begin
                    pc_ld   = 1'b1;
                    state_d = REQ;
                end else if (inst_ready) begin
                    pc_ld   = 1'b1;
                    pc_d    = pc_q + XLEN'(4);
                    state_d = REQ;
                end
            end
`ifdef FETCH_MISALIGN_CHK_EN
            HALT: begin
                if (trap_valid) begin
                    pc_ld   = 1'b1;
                    state_d = REQ;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
`ifdef FETCH_MISALIGN_CHK_EN
        // Any accepted redirect to a misaligned target parks the sequencer.
        if (pc_ld && redir && tgt_bad) begin
            state_d = HALT;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    REG_RST #(
        .W      (XLEN),
        .RSTVAL (RESET_PC)
    ) u_pc_reg (
        .clk (clk),
        .rst (rst),
        .en  (pc_ld),
        .d   (pc_d),
        .q   (pc_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else if (cap) begin
            inst_q    <= imem_rsp_data;
            inst_pc_q <= pc_q;
        end
    end

    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (state_q == HOLD);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;

`ifdef FETCH_MISALIGN_CHK_EN
    assign fetch_misalign    = (state_q == HALT);
    assign fetch_misalign_pc = (state_q == HALT) ? pc_q : '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: memory and decode models drive the DUT; a monitor checks the
// delivered instruction stream against an architectural next-PC model kept in a queue.
module tb_fetch_ctrl;

    localparam logic [63:0] RST_PC = 64'h8000_0000;
`ifdef FETCH_MISALIGN_CHK_EN
    localparam logic [63:0] TMASK  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] GMASK  = 64'hFFFF_FFFF_FFFF_FFFC;
`else
    localparam logic [63:0] TMASK  = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [63:0] GMASK  = 64'hFFFF_FFFF_FFFF_FFFF;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trap_valid = 1'b0;
    logic [63:0] trap_pc = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] inst_pc;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        fetch_misalign;
    logic [63:0] fetch_misalign_pc;
`endif

    always #5 clk = ~clk;

    fetch_ctrl #(
        .XLEN     (64),
        .RESET_PC (RST_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .fetch_misalign    (fetch_misalign),
        .fetch_misalign_pc (fetch_misalign_pc)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_deliv = 0;
    bit          mon_en = 1'b0;
    logic [63:0] exp_pc;
    logic [63:0] exp_q[$];
    logic [63:0] acc_addr[$];
    int          acc_cyc[$];
    bit          pend = 1'b0;
    int          pend_dly = 0;
    logic [63:0] pend_addr = '0;
    int          lat_min = 1;
    int          lat_max = 1;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ (a[31:0] << 9) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One cycle of stimulus: memory response, handshake inputs, architectural model update.
    task automatic step(input bit rr, input bit dr, input bit tv, input logic [63:0] tp,
                        input bit rv, input logic [63:0] rp);
        imem_rsp_valid = 1'b0;
        if (pend) begin
            if (pend_dly <= 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_addr);
                pend           = 1'b0;
            end else begin
                pend_dly--;
            end
        end
        imem_req_ready = rr;
        inst_ready     = dr;
        trap_valid     = tv;
        trap_pc        = tp;
        redirect_valid = rv;
        redirect_pc    = rp;
        if (inst_valid && dr && !tv && !rv) begin
            exp_q.push_back(exp_pc);
            exp_pc = exp_pc + 64'd4;
        end
        if (tv) exp_pc = tp & TMASK;
        else if (rv) exp_pc = rp & TMASK;
        if (imem_req_valid && rr) begin
            chk("one_outstanding", 64'(pend), 64'd0);
            pend      = 1'b1;
            pend_dly  = int'($urandom_range(lat_max, lat_min));
            pend_addr = imem_req_addr;
            acc_addr.push_back(imem_req_addr);
            acc_cyc.push_back(cyc);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hold(input string name);
        for (int i = 0; i < 20; i++) begin
            if (inst_valid) return;
            step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout inst_valid=0 required=1", name);
    endtask

    task automatic step_until_accept(input string name, input bit no_inst, output logic [63:0] a);
        int n0;
        n0 = acc_addr.size();
        for (int i = 0; i < 20; i++) begin
            if (no_inst) chk({name, "_no_inst"}, 64'(inst_valid), 64'd0);
            step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
            if (acc_addr.size() > n0) begin
                a = acc_addr[$];
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout accepted=none required=1", name);
        a = 'x;
    endtask

    // Monitor: pops expectations when decode takes an instruction; checks stall stability.
    bit          p_req_stall = 1'b0;
    bit          p_hold_stall = 1'b0;
    logic [63:0] p_addr;
    logic [63:0] p_ipc;
    logic [31:0] p_inst;
    logic [63:0] mon_e;

    always @(negedge clk) begin
        if (rst || !mon_en) begin
            p_req_stall  = 1'b0;
            p_hold_stall = 1'b0;
        end else begin
            if (p_req_stall) begin
                chk("req_stall_valid", 64'(imem_req_valid), 64'd1);
                chk("req_stall_addr", imem_req_addr, p_addr);
            end
            if (p_hold_stall) begin
                chk("hold_stall_valid", 64'(inst_valid), 64'd1);
                chk("hold_stall_inst", 64'(inst), 64'(p_inst));
                chk("hold_stall_pc", inst_pc, p_ipc);
            end
            if (inst_valid && inst_ready && !trap_valid && !redirect_valid) begin
                n_deliv++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL deliver_unexpected actual_pc=%h required=none", inst_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("inst_pc", inst_pc, mon_e);
                    chk("inst_word", 64'(inst), 64'(mem_word(mon_e)));
                end
            end
            p_req_stall  = imem_req_valid && !imem_req_ready && !trap_valid && !redirect_valid;
            p_hold_stall = inst_valid && !inst_ready && !trap_valid && !redirect_valid;
            p_addr       = imem_req_addr;
            p_ipc        = inst_pc;
            p_inst       = inst;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] a;
        logic [63:0] t1;
        logic [63:0] t2;
        int          ev;
        int          n0;
        exp_pc = RST_PC;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_inst_pc", inst_pc, 64'd0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        rst    = 1'b0;
        mon_en = 1'b1;
        chk("idle_req_valid", 64'(imem_req_valid), 64'd0);

        // Zero-wait memory, decode always ready.
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        chk("first_req_valid", 64'(imem_req_valid), 64'd1);
        chk("first_req_addr", imem_req_addr, RST_PC);
        repeat (8) step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        chk("thru_count", 64'(acc_addr.size() >= 3), 64'd1);
        if (acc_addr.size() >= 3) begin
            chk("thru_addr1", acc_addr[1], RST_PC + 64'd4);
            chk("thru_addr2", acc_addr[2], RST_PC + 64'd8);
            chk("thru_gap1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd3);
            chk("thru_gap2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd3);
        end

        // Decode stall in HOLD.
        wait_hold("hold");
        chk("hold_inst_pc", inst_pc, RST_PC + 64'd8);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
            chk("hold_no_req", 64'(imem_req_valid), 64'd0);
        end
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        chk("resume_valid", 64'(imem_req_valid), 64'd1);
        chk("resume_addr", imem_req_addr, RST_PC + 64'd12);

        // Redirect during WAIT; stale response arrives two cycles later.
        lat_min = 3;
        lat_max = 3;
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, 64'h8000_1000);
        lat_min = 1;
        lat_max = 1;
        step_until_accept("wait_redir", 1'b1, a);
        chk("wait_redir_addr", a, 64'h8000_1000);

        // Trap and redirect together in HOLD.
        wait_hold("hold2");
        chk("hold2_inst_pc", inst_pc, 64'h8000_1000);
        step(1'b1, 1'b1, 1'b1, 64'h100, 1'b1, 64'h200);
        step_until_accept("trap_prio", 1'b1, a);
        chk("trap_prio_addr", a, 64'h100);

        // Request stall with a redirect in the middle.
        wait_hold("hold3");
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        chk("stall_addr_a", imem_req_addr, 64'h104);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        chk("stall_addr_b", imem_req_addr, 64'h104);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1, 64'h3000);
        chk("stall_redir_valid", 64'(imem_req_valid), 64'd1);
        chk("stall_redir_addr", imem_req_addr, 64'h3000);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        step_until_accept("stall_acc", 1'b0, a);
        chk("stall_acc_addr", a, 64'h3000);

`ifdef FETCH_MISALIGN_CHK_EN
        wait_hold("hold4");
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1, 64'h8000_0002);
        chk("mis_flag", 64'(fetch_misalign), 64'd1);
        chk("mis_pc", fetch_misalign_pc, 64'h8000_0002);
        chk("mis_no_req", 64'(imem_req_valid), 64'd0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, 64'h5000);
        chk("mis_redir_ignored", fetch_misalign_pc, 64'h8000_0002);
        chk("mis_still_halt", 64'(imem_req_valid), 64'd0);
        step(1'b1, 1'b0, 1'b1, 64'h100, 1'b0, '0);
        chk("mis_exit_flag", 64'(fetch_misalign), 64'd0);
        chk("mis_exit_valid", 64'(imem_req_valid), 64'd1);
        chk("mis_exit_addr", imem_req_addr, 64'h100);
`endif

        // Randomized traffic.
        lat_min = 1;
        lat_max = 4;
        n_deliv = 0;
        for (int i = 0; i < 3000; i++) begin
            ev = int'($urandom_range(99, 0));
            t1 = {$urandom, $urandom} & GMASK;
            t2 = {$urandom, $urandom} & GMASK;
            step($urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0,
                 ev < 4, t1, (ev < 2) || (ev >= 4 && ev < 10), t2);
        end
        chk("live_deliveries", 64'(n_deliv > 100), 64'd1);

        // Reset in the middle of traffic.
        rst = 1'b1;
        #1;
        chk("midrst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("midrst_inst_valid", 64'(inst_valid), 64'd0);
        chk("midrst_addr", imem_req_addr, RST_PC);
        pend           = 1'b0;
        imem_rsp_valid = 1'b0;
        trap_valid     = 1'b0;
        redirect_valid = 1'b0;
        exp_pc         = RST_PC;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        n0  = acc_addr.size();
        repeat (12) step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        chk("postrst_count", 64'(acc_addr.size() > n0), 64'd1);
        if (acc_addr.size() > n0) chk("postrst_addr", acc_addr[n0], RST_PC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer for the instruction fetch unit. It owns the fetch PC and issues one instruction-memory request at a time over a valid/ready channel. It accepts branch redirects and trap redirects, and drops responses made stale by a redirect. It holds each fetched instruction until decode accepts it, so the pipeline can stall from decode back to fetch.

## Interface
Parameters:
- XLEN, default `XLEN: address and PC width.
- RESET_PC, default 64'h8000_0000: first fetch address after reset.

Ports:
- clk  in  1  clock, all state rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- trap_valid  in  1  trap redirect request, highest priority.
- trap_pc  in  XLEN  trap target.
- redirect_valid  in  1  branch/jump redirect request.
- redirect_pc  in  XLEN  redirect target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  fetch address; equals the PC register.
- imem_rsp_valid  in  1  response for the single outstanding request.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  held instruction valid to decode.
- inst_ready  in  1  decode accepts the instruction.
- inst  out  32  held instruction.
- inst_pc  out  XLEN  PC of the held instruction.

## Operation
- States: IDLE, REQ, WAIT, DROP, HOLD.
- Outputs are decoded from the state: imem_req_valid = (REQ); inst_valid = (HOLD).
- Redirect target selection: when both are valid, trap_valid wins over redirect_valid. Either one is called a "redirect" below. The new PC is the selected target.
- IDLE: PC = RESET_PC. Unconditionally goes to REQ on the next cycle.
- REQ:
  - If the request is accepted (valid & ready) with no redirect, go to WAIT.
  - If accepted in the same cycle as a redirect, load the target into PC and go to DROP.
  - If not accepted and a redirect is present, load the target into PC and stay in REQ. The address may change while valid is high only in this case.
- WAIT:
  - imem_rsp_valid with no redirect: capture data into inst, capture PC into inst_pc, go to HOLD.
  - Redirect with no response: load PC, go to DROP.
  - Redirect in the same cycle as a response: discard the response, load PC, go to REQ.
- DROP:
  - Wait for the stale response and discard it, then go to REQ.
  - A further redirect while in DROP overwrites PC and does not change the state.
- HOLD:
  - inst_ready with no redirect: PC = PC + 4 (XLEN-bit, wraps modulo 2^XLEN), go to REQ.
  - Redirect, whether or not inst_ready is high: drop the held instruction, load PC, go to REQ. The instruction counts as consumed only if inst_ready was high.
- Exactly one request is outstanding at a time. An imem_rsp_valid seen outside WAIT/DROP is ignored.

## Timing
- Reset values: state IDLE, PC RESET_PC, inst 0, inst_pc 0, imem_req_valid 0, inst_valid 0.
- First imem_req_valid is asserted 1 cycle after rst deasserts.
- Response to inst_valid: 1 cycle (registered capture).
- Throughput with a zero-wait memory: one instruction per 3 cycles (REQ, WAIT, HOLD).
- A redirect takes effect as imem_req_addr on the next REQ cycle; with no pending response, that is the cycle after the redirect.
- Asserting rst mid-transaction forces IDLE immediately. The memory must also be reset; no response is expected after reset.

## Configuration
- FETCH_MISALIGN_CHK_EN defined:
  - Adds outputs fetch_misalign (1) and fetch_misalign_pc (XLEN).
  - A selected redirect target with target[1:0] != 0 is not fetched. The block enters a sixth state, HALT, with fetch_misalign = 1 and fetch_misalign_pc = target.
  - HALT exits only on a trap_valid, which loads trap_pc and goes to REQ (the trap target is itself checked the same way).
- Not defined: the ports are absent, bits [1:0] of every redirect target are forced to 0, and HALT does not exist.

## Structure
- Shared package holds the state encoding constants, RESET_PC default, and instruction width (32).
- The PC register is the existing REG_RST primitive, with RSTVAL = RESET_PC and enable = PC-load condition.
- The next-PC mux and the FSM live in this module; no further sub-module.

## Test plan
- Reset release, memory always ready, 1-cycle response, inst_ready = 1 -> addresses 0x80000000, 0x80000004, 0x80000008 issued every 3 cycles; inst_pc matches each address.
- inst_ready held low for 5 cycles in HOLD -> inst/inst_pc stable, no new request; fetch resumes at PC + 4 one cycle after ready.
- redirect_valid to 0x80001000 during WAIT, response 2 cycles later -> response discarded, next request to 0x80001000, no inst_valid for the stale data.
- trap_valid (0x100) and redirect_valid (0x200) in the same cycle during HOLD -> held instruction dropped, next request to 0x100.
- imem_req_ready low for 4 cycles with a redirect mid-stall -> address switches to the target, valid stays high, accepted address equals the target.
- With FETCH_MISALIGN_CHK_EN, redirect to 0x80000002 -> fetch_misalign = 1 and fetch_misalign_pc = 0x80000002, no request; a following trap to 0x100 resumes fetch at 0x100.
